// File: rtl/slow_timer.sv
// slow_timer: holds the CPU on the slow clock for a programmable time after a slow-device access.
// Ports:
//   CLK, nPOR            clock (rising edge) and asynchronous active-low reset
//   BACT                 bus cycle active
//   IACKCS..SndCS        device selects, valid while BACT is high
//   SlowIACK..SlowSnd    per-device slow enables
//   SlowClockGate        allows ClockGate while slow
//   SlowTimeout[3:0]     hold reload value in Tick units
//   Tick                 single-cycle timebase strobe
//   SlowAck              clock switcher reports the slow clock is running
//   SlowReq              registered request for the slow clock (SWITCH or SLOW)
//   ClockGate            registered SlowClockGate while in SLOW
//   SlowCount[3:0]       remaining hold count
module slow_timer (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  input  logic       Tick,
  input  logic       SlowAck,
  output logic       SlowReq,
  output logic       ClockGate,
  output logic [3:0] SlowCount
);
  typedef enum logic [1:0] {FAST, SWITCH, SLOW, RELEASE} state_t;
  state_t state, stateNext;
  logic BACTr, armed, slowHit, slowStart;
  logic [3:0] countNext;
  assign slowHit = (IACKCS && SlowIACK) || (VIACS && SlowVIA) || (IWMCS && SlowIWM) ||
                   (SCCCS && SlowSCC) || (SCSICS && SlowSCSI) || (SndCS && SlowSnd);
  // armed stays low for the first cycle after reset so a BACT already high
  // when nPOR rises is not mistaken for a fresh access start
  assign slowStart = armed && BACT && !BACTr && slowHit;
  always_comb begin
    stateNext = state;
    countNext = SlowCount;
    case (state)
      FAST: if (slowStart) begin
        stateNext = SWITCH;
        countNext = SlowTimeout;
      end
      SWITCH: begin
        if (slowStart) countNext = SlowTimeout;
        if (SlowAck) stateNext = SLOW;
      end
      SLOW: if (slowStart) countNext = SlowTimeout;
        else if (!BACT) begin
          if (SlowCount == 4'd0) stateNext = RELEASE;
          else if (Tick) countNext = SlowCount - 4'd1;
        end
      RELEASE: if (slowStart) begin
        stateNext = SWITCH;
        countNext = SlowTimeout;
      end else if (!SlowAck) stateNext = FAST;
      default: stateNext = FAST;
    endcase
  end
  always_ff @(posedge CLK or negedge nPOR)
    if (!nPOR) begin
      state <= FAST;
      SlowCount <= 4'd0;
      BACTr <= 1'b0;
      armed <= 1'b0;
      SlowReq <= 1'b0;
      ClockGate <= 1'b0;
    end else begin
      state <= stateNext;
      SlowCount <= countNext;
      BACTr <= BACT;
      armed <= 1'b1;
      SlowReq <= (stateNext == SWITCH) || (stateNext == SLOW);
      ClockGate <= SlowClockGate && (state == SLOW);
    end
endmodule

// File: tb/tb_slow_timer.sv
// tb_slow_timer: directed self-checking bench for slow_timer.
module tb_slow_timer;
  localparam int IACK = 0, VIA = 1, IWM = 2, SCC = 3, SCSI = 4, SND = 5;
  logic CLK = 1'b0, nPOR = 1'b0, BACT = 1'b0, SlowClockGate = 1'b0, Tick = 1'b0, SlowAck = 1'b0;
  logic [5:0] cs = 6'd0, en = 6'd0;
  logic [3:0] SlowTimeout = 4'd0;
  logic SlowReq, ClockGate;
  logic [3:0] SlowCount;
  int nVec = 0, nBad = 0;
  slow_timer dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT),
    .IACKCS(cs[IACK]), .VIACS(cs[VIA]), .IWMCS(cs[IWM]),
    .SCCCS(cs[SCC]), .SCSICS(cs[SCSI]), .SndCS(cs[SND]),
    .SlowIACK(en[IACK]), .SlowVIA(en[VIA]), .SlowIWM(en[IWM]),
    .SlowSCC(en[SCC]), .SlowSCSI(en[SCSI]), .SlowSnd(en[SND]),
    .SlowClockGate(SlowClockGate), .SlowTimeout(SlowTimeout), .Tick(Tick),
    .SlowAck(SlowAck), .SlowReq(SlowReq), .ClockGate(ClockGate), .SlowCount(SlowCount)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic doReset();
    nPOR = 1'b0;
    step();
    nPOR = 1'b1;
    step();
  endtask
  initial begin
    #3;
    check("rst req", SlowReq, 0);
    check("rst gate", ClockGate, 0);
    check("rst count", SlowCount, 0);
    step();
    nPOR = 1'b1;
    step();
    // first slow access through the VIA, then drain three Ticks
    en[VIA] = 1'b1; SlowTimeout = 4'd3; cs[VIA] = 1'b1; BACT = 1'b1;
    step();
    check("t1 req", SlowReq, 1);
    check("t1 count", SlowCount, 3);
    BACT = 1'b0; cs = 6'd0; SlowAck = 1'b1; SlowTimeout = 4'd9;
    step();
    check("t1 slow req", SlowReq, 1);
    step();
    check("t1 no tick", SlowCount, 3);
    Tick = 1'b1;
    step(); check("t1 tick a", SlowCount, 2);
    step(); check("t1 tick b", SlowCount, 1);
    step(); check("t1 tick c", SlowCount, 0);
    step();
    check("t1 release req", SlowReq, 0);
    check("t1 no wrap", SlowCount, 0);
    Tick = 1'b0; SlowAck = 1'b0;
    step();
    // disabled device does not request
    cs[SCC] = 1'b1; BACT = 1'b1;
    step();
    check("t2 req", SlowReq, 0);
    check("t2 count", SlowCount, 0);
    BACT = 1'b0; cs = 6'd0;
    step();
    // retrigger with coincident Tick, then BACT held across Ticks
    en[IWM] = 1'b1; SlowTimeout = 4'd5; cs[IWM] = 1'b1; BACT = 1'b1;
    step();
    check("t3 count", SlowCount, 5);
    BACT = 1'b0; cs = 6'd0; SlowAck = 1'b1;
    step();
    Tick = 1'b1;
    repeat (4) step();
    check("t3 count one", SlowCount, 1);
    SlowTimeout = 4'd7; cs[IWM] = 1'b1; BACT = 1'b1;
    step();
    check("t3 reload", SlowCount, 7);
    check("t3 reload req", SlowReq, 1);
    repeat (10) begin
      Tick = 1'b1; step();
      Tick = 1'b0; step();
    end
    check("t3 held", SlowCount, 7);
    check("t3 held req", SlowReq, 1);
    BACT = 1'b0; cs = 6'd0; Tick = 1'b1;
    repeat (7) step();
    check("t3 drained", SlowCount, 0);
    check("t3 drained req", SlowReq, 1);
    step();
    check("t3 release", SlowReq, 0);
    Tick = 1'b0; SlowTimeout = 4'd2; cs[IWM] = 1'b1; BACT = 1'b1;
    step();
    check("t3 rel restart req", SlowReq, 1);
    check("t3 rel restart count", SlowCount, 2);
    BACT = 1'b0; cs = 6'd0;
    step();
    cs[SCC] = 1'b1; BACT = 1'b1;
    step();
    check("t3 nonslow", SlowCount, 2);
    BACT = 1'b0; cs = 6'd0; Tick = 1'b1;
    repeat (2) step();
    Tick = 1'b0;
    step();
    check("t3 end release", SlowReq, 0);
    SlowAck = 1'b0;
    step();
    // zero timeout with clock gating
    en[SND] = 1'b1; SlowClockGate = 1'b1; SlowTimeout = 4'd0; cs[SND] = 1'b1; BACT = 1'b1;
    step();
    check("t4 req", SlowReq, 1);
    check("t4 gate switch", ClockGate, 0);
    SlowAck = 1'b1;
    step();
    check("t4 gate entry", ClockGate, 0);
    step();
    check("t4 gate on", ClockGate, 1);
    check("t4 slow req", SlowReq, 1);
    BACT = 1'b0; cs = 6'd0;
    step();
    check("t4 release req", SlowReq, 0);
    check("t4 gate lag", ClockGate, 1);
    step();
    check("t4 gate off", ClockGate, 0);
    SlowAck = 1'b0; SlowClockGate = 1'b0;
    step();
    // asynchronous reset in SWITCH with BACT held high across release
    en[SCSI] = 1'b1; SlowTimeout = 4'd4; cs[SCSI] = 1'b1; BACT = 1'b1;
    step();
    check("t5 req", SlowReq, 1);
    #2 nPOR = 1'b0;
    #1;
    check("t5 async req", SlowReq, 0);
    check("t5 async count", SlowCount, 0);
    check("t5 async gate", ClockGate, 0);
    step();
    nPOR = 1'b1;
    step();
    step();
    check("t5 held no start", SlowReq, 0);
    check("t5 held count", SlowCount, 0);
    BACT = 1'b0;
    step();
    BACT = 1'b1;
    step();
    check("t5 new req", SlowReq, 1);
    check("t5 new count", SlowCount, 4);
    BACT = 1'b0; cs = 6'd0;
    // each device pair alone, enabled and disabled
    SlowTimeout = 4'd6;
    for (int i = 0; i < 6; i++) begin
      doReset();
      en = 6'b1 << i; cs = 6'b1 << i; BACT = 1'b1;
      step();
      check($sformatf("dev%0d on", i), SlowReq, 1);
      check($sformatf("dev%0d count", i), SlowCount, 6);
      BACT = 1'b0; cs = 6'd0;
      doReset();
      en = ~(6'b1 << i); cs = 6'b1 << i; BACT = 1'b1;
      step();
      check($sformatf("dev%0d off", i), SlowReq, 0);
      BACT = 1'b0; cs = 6'd0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
